md4_digest_accum: RTL and testbench

MD4_DIGEST_ACCUM -- requirements
Module: md4_digest_accum

---
 rtl/md4_pkg.sv | 21 ++
 rtl/md4_add4x32.sv | 23 ++
 rtl/md4_digest_accum.sv | 117 +++++++++++
 tb/tb_md4_digest_accum.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md4_pkg.sv
// Shared MD4 definitions: chaining IVs, accumulator state encoding and byte-swap helper.
// Reused by the round stages as well as the digest accumulator.
package md4_pkg;

  localparam logic [31:0] MD4_IV_A = 32'h67452301;
  localparam logic [31:0] MD4_IV_B = 32'hefcdab89;
  localparam logic [31:0] MD4_IV_C = 32'h98badcfe;
  localparam logic [31:0] MD4_IV_D = 32'h10325476;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } md4_state_e;

  // MD4 emits words little-endian, so the digest byte stream is each word reversed.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/md4_add4x32.sv
// Four independent 32-bit lanes, each summed modulo 2^32 (carry out dropped).
// Purely combinational; the caller owns all state.
module md4_add4x32 (
  input  logic [31:0] x_a,
  input  logic [31:0] x_b,
  input  logic [31:0] x_c,
  input  logic [31:0] x_d,
  input  logic [31:0] y_a,
  input  logic [31:0] y_b,
  input  logic [31:0] y_c,
  input  logic [31:0] y_d,
  output logic [31:0] sum_a,
  output logic [31:0] sum_b,
  output logic [31:0] sum_c,
  output logic [31:0] sum_d
);

  assign sum_a = x_a + y_a;
  assign sum_b = x_b + y_b;
  assign sum_c = x_c + y_c;
  assign sum_d = x_d + y_d;

endmodule

// File: rtl/md4_digest_accum.sv
// MD4 chaining-value accumulator: folds each block's round-3 outputs into h_*
// and presents the byte-ordered digest once the final block has been absorbed.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no message in progress; h_* / blk_count hold last values
// ST_ACCUM | accepting round-3 outputs, one block per transfer
// ST_DONE  | final block absorbed, digest valid until consumer takes it
module md4_digest_accum
  import md4_pkg::*;
#(
  parameter int          CNT_W = 16,
  parameter logic [31:0] IV_A  = MD4_IV_A,
  parameter logic [31:0] IV_B  = MD4_IV_B,
  parameter logic [31:0] IV_C  = MD4_IV_C,
  parameter logic [31:0] IV_D  = MD4_IV_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [31:0]        in_a,
  input  logic [31:0]        in_b,
  input  logic [31:0]        in_c,
  input  logic [31:0]        in_d,
  output logic [31:0]        h_a,
  output logic [31:0]        h_b,
  output logic [31:0]        h_c,
  output logic [31:0]        h_d,
  output logic [127:0]       digest,
  output logic               digest_valid,
  input  logic               digest_ready,
  output logic [CNT_W-1:0]   blk_count,
  output logic               busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  md4_state_e  state;
  logic [31:0] sum_a, sum_b, sum_c, sum_d;

  md4_add4x32 u_add (
    .x_a   (h_a),
    .x_b   (h_b),
    .x_c   (h_c),
    .x_d   (h_d),
    .y_a   (in_a),
    .y_b   (in_b),
    .y_c   (in_c),
    .y_d   (in_d),
    .sum_a (sum_a),
    .sum_b (sum_b),
    .sum_c (sum_c),
    .sum_d (sum_d)
  );

  assign digest = {bswap32(h_a), bswap32(h_b), bswap32(h_c), bswap32(h_d)};

  // start outranks everything except reset, including a pending transfer or digest_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      h_a          <= IV_A;
      h_b          <= IV_B;
      h_c          <= IV_C;
      h_d          <= IV_D;
      blk_count    <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      digest_valid <= 1'b0;
    end else if (start) begin
      state        <= ST_ACCUM;
      h_a          <= IV_A;
      h_b          <= IV_B;
      h_c          <= IV_C;
      h_d          <= IV_D;
      blk_count    <= '0;
      in_ready     <= 1'b1;
      busy         <= 1'b1;
      digest_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (in_valid) begin
            h_a <= sum_a;
            h_b <= sum_b;
            h_c <= sum_c;
            h_d <= sum_d;
            if (blk_count != CNT_MAX) blk_count <= blk_count + CNT_ONE;
            if (in_last) begin
              state        <= ST_DONE;
              in_ready     <= 1'b0;
              busy         <= 1'b0;
              digest_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (digest_ready) begin
            state        <= ST_IDLE;
            digest_valid <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          in_ready     <= 1'b0;
          busy         <= 1'b0;
          digest_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md4_digest_accum.sv
// Self-checking bench for md4_digest_accum against an arithmetic reference model.
// A narrow block counter keeps the saturation case short.
module tb_md4_digest_accum;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n, start, in_valid, in_last, digest_ready;
  logic [31:0]    in_a, in_b, in_c, in_d;
  logic           in_ready, digest_valid, busy;
  logic [31:0]    h_a, h_b, h_c, h_d;
  logic [127:0]   digest;
  logic [CW-1:0]  blk_count;

  int checks = 0;
  int errors = 0;

  bit [31:0] iv[4] = '{32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
  bit [31:0] mh[4];
  int        mcnt;

  always #5 clk = ~clk;

  md4_digest_accum #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_c         (in_c),
    .in_d         (in_d),
    .h_a          (h_a),
    .h_b          (h_b),
    .h_c          (h_c),
    .h_d          (h_d),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .blk_count    (blk_count),
    .busy         (busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [127:0] exp_h();
    return {mh[0], mh[1], mh[2], mh[3]};
  endfunction

  // Digest byte k (k=0 is the top byte) is byte (k%4) of word k/4, little-endian.
  function automatic logic [127:0] exp_digest();
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < 16; k++)
      d[127 - 8*k -: 8] = mh[k/4] >> (8 * (k % 4));
    return d;
  endfunction

  task automatic model_start();
    for (int i = 0; i < 4; i++) mh[i] = iv[i];
    mcnt = 0;
  endtask

  task automatic model_xfer(input bit [31:0] a, b, c, d);
    mh[0] = mh[0] + a;
    mh[1] = mh[1] + b;
    mh[2] = mh[2] + c;
    mh[3] = mh[3] + d;
    if (mcnt < CMAX) mcnt++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    start = 0; in_valid = 0; in_last = 0; digest_ready = 0;
    in_a = 0; in_b = 0; in_c = 0; in_d = 0;
  endtask

  task automatic do_start();
    quiet();
    start = 1;
    tick();
    start = 0;
    model_start();
  endtask

  task automatic do_block(input bit [31:0] a, b, c, d, input bit last);
    quiet();
    in_valid = 1; in_last = last;
    in_a = a; in_b = b; in_c = c; in_d = d;
    tick();
    model_xfer(a, b, c, d);
    quiet();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; start = 1; in_valid = 1; in_last = 1; digest_ready = 1;
    in_a = $urandom; in_b = $urandom; in_c = $urandom; in_d = $urandom;
    tick();
    tick();
    model_start();
    checks++;
    if ({in_ready, busy, digest_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got rdy/busy/dv=%b exp 000", {in_ready, busy, digest_valid});
    end
    checks++;
    if ({h_a, h_b, h_c, h_d} !== exp_h() || blk_count !== '0) begin
      errors++;
      $display("FAIL reset_state: got h=%h cnt=%0d exp h=%h cnt=0", {h_a, h_b, h_c, h_d}, blk_count, exp_h());
    end
    quiet();
    rst_n = 1;
    tick();
  endtask

  task automatic test_zero_block();
    do_start();
    checks++;
    if ({in_ready, busy, digest_valid} !== 3'b110 || blk_count !== '0) begin
      errors++;
      $display("FAIL start_flags: got rdy/busy/dv=%b cnt=%0d exp 110 cnt=0", {in_ready, busy, digest_valid}, blk_count);
    end
    do_block(0, 0, 0, 0, 1);
    checks++;
    if (digest_valid !== 1'b1 || digest !== 128'h0123456789abcdeffedcba9876543210 || blk_count !== CW'(1)) begin
      errors++;
      $display("FAIL zero_block: got dv=%b digest=%h cnt=%0d exp dv=1 digest=0123456789abcdeffedcba9876543210 cnt=1",
               digest_valid, digest, blk_count);
    end
    checks++;
    if ({in_ready, busy} !== 2'b00) begin
      errors++;
      $display("FAIL done_flags: got rdy/busy=%b exp 00", {in_ready, busy});
    end
    digest_ready = 1;
    tick();
    quiet();
    checks++;
    if (digest_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_release: got dv=%b exp 0", digest_valid);
    end
  endtask

  task automatic test_wrap();
    do_start();
    do_block(32'h98badcff, 0, 0, 0, 1);
    checks++;
    if (h_a !== 32'h0 || digest[127:96] !== 32'h0 || digest !== exp_digest()) begin
      errors++;
      $display("FAIL wrap: got h_a=%h digest=%h exp h_a=00000000 digest=%h", h_a, digest, exp_digest());
    end
    digest_ready = 1;
    tick();
    quiet();
  endtask

  task automatic test_three_blocks_hold();
    logic [127:0] held;
    do_start();
    for (int i = 0; i < 3; i++) do_block(1, 1, 1, 1, i == 2);
    checks++;
    if (h_a !== 32'h67452304 || blk_count !== CW'(3) || digest_valid !== 1'b1) begin
      errors++;
      $display("FAIL three_blocks: got h_a=%h cnt=%0d dv=%b exp h_a=67452304 cnt=3 dv=1", h_a, blk_count, digest_valid);
    end
    held = exp_digest();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_last = $urandom_range(0, 1);
      in_a = $urandom; in_b = $urandom; in_c = $urandom; in_d = $urandom;
      tick();
      checks++;
      if (digest !== held || digest_valid !== 1'b1 || blk_count !== CW'(3) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL done_hold[%0d]: got digest=%h dv=%b cnt=%0d rdy=%b exp digest=%h dv=1 cnt=3 rdy=0",
                 i, digest, digest_valid, blk_count, in_ready, held);
      end
    end
    quiet();
    digest_ready = 1;
    tick();
    quiet();
    checks++;
    if (digest_valid !== 1'b0 || busy !== 1'b0 || {h_a, h_b, h_c, h_d} !== exp_h() || blk_count !== CW'(3)) begin
      errors++;
      $display("FAIL to_idle: got dv=%b busy=%b h=%h cnt=%0d exp dv=0 busy=0 h=%h cnt=3",
               digest_valid, busy, {h_a, h_b, h_c, h_d}, blk_count, exp_h());
    end
  endtask

  task automatic test_ignore_invalid();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_last = $urandom_range(0, 1); digest_ready = $urandom_range(0, 1);
      in_a = $urandom; in_b = $urandom; in_c = $urandom; in_d = $urandom;
      tick();
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || digest_valid !== 1'b0 ||
          {h_a, h_b, h_c, h_d} !== exp_h() || blk_count !== CW'(mcnt)) begin
        errors++;
        $display("FAIL idle_ignore[%0d]: got rdy=%b busy=%b dv=%b h=%h cnt=%0d exp 0 0 0 h=%h cnt=%0d",
                 i, in_ready, busy, digest_valid, {h_a, h_b, h_c, h_d}, blk_count, exp_h(), mcnt);
      end
    end
    quiet();
  endtask

  task automatic test_start_priority();
    do_start();
    do_block($urandom, $urandom, $urandom, $urandom, 0);
    start = 1; in_valid = 1; in_last = 1;
    in_a = $urandom; in_b = $urandom; in_c = $urandom; in_d = $urandom;
    tick();
    quiet();
    model_start();
    checks++;
    if ({h_a, h_b, h_c, h_d} !== exp_h() || blk_count !== '0 || {in_ready, busy, digest_valid} !== 3'b110) begin
      errors++;
      $display("FAIL start_vs_valid: got h=%h cnt=%0d rdy/busy/dv=%b exp h=%h cnt=0 110",
               {h_a, h_b, h_c, h_d}, blk_count, {in_ready, busy, digest_valid}, exp_h());
    end
    do_block($urandom, $urandom, $urandom, $urandom, 1);
    start = 1; digest_ready = 1;
    tick();
    quiet();
    model_start();
    checks++;
    if ({h_a, h_b, h_c, h_d} !== exp_h() || blk_count !== '0 || {in_ready, busy, digest_valid} !== 3'b110) begin
      errors++;
      $display("FAIL start_in_done: got h=%h cnt=%0d rdy/busy/dv=%b exp h=%h cnt=0 110",
               {h_a, h_b, h_c, h_d}, blk_count, {in_ready, busy, digest_valid}, exp_h());
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    do_block($urandom, $urandom, $urandom, $urandom, 0);
    rst_n = 0; in_valid = 1; in_last = 1;
    tick();
    rst_n = 1;
    quiet();
    model_start();
    checks++;
    if ({h_a, h_b, h_c, h_d} !== exp_h() || blk_count !== '0 || {in_ready, busy, digest_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid: got h=%h cnt=%0d rdy/busy/dv=%b exp h=%h cnt=0 000",
               {h_a, h_b, h_c, h_d}, blk_count, {in_ready, busy, digest_valid}, exp_h());
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_last = 1;
      tick();
      checks++;
      if (digest_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_nodigest[%0d]: got dv=%b exp 0", i, digest_valid);
      end
    end
    quiet();
  endtask

  task automatic test_saturation();
    do_start();
    for (int i = 0; i < CMAX + 3; i++)
      do_block($urandom, $urandom, $urandom, $urandom, i == CMAX + 2);
    checks++;
    if (blk_count !== CW'(CMAX) || {h_a, h_b, h_c, h_d} !== exp_h() || digest !== exp_digest()) begin
      errors++;
      $display("FAIL saturation: got cnt=%0d h=%h exp cnt=%0d h=%h", blk_count, {h_a, h_b, h_c, h_d}, CMAX, exp_h());
    end
    digest_ready = 1;
    tick();
    quiet();
  endtask

  task automatic test_random_messages();
    for (int m = 0; m < 8; m++) begin
      int nblk;
      nblk = $urandom_range(1, 6);
      do_start();
      for (int b = 0; b < nblk; b++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          in_a = $urandom; in_b = $urandom; in_last = $urandom_range(0, 1);
          tick();
        end
        do_block($urandom, $urandom, $urandom, $urandom, b == nblk - 1);
        checks++;
        if ({h_a, h_b, h_c, h_d} !== exp_h() || blk_count !== CW'(mcnt) || digest_valid !== (b == nblk - 1)) begin
          errors++;
          $display("FAIL random[%0d.%0d]: got h=%h cnt=%0d dv=%b exp h=%h cnt=%0d dv=%0d",
                   m, b, {h_a, h_b, h_c, h_d}, blk_count, digest_valid, exp_h(), mcnt, b == nblk - 1);
        end
      end
      checks++;
      if (digest !== exp_digest()) begin
        errors++;
        $display("FAIL random_digest[%0d]: got %h exp %h", m, digest, exp_digest());
      end
      repeat ($urandom_range(0, 3)) tick();
      digest_ready = 1;
      tick();
      quiet();
    end
  endtask

  initial begin
    rst_n = 0;
    quiet();
    model_start();
    test_reset();
    test_zero_block();
    test_wrap();
    test_three_blocks_hold();
    test_ignore_invalid();
    test_start_priority();
    test_reset_mid();
    test_ignore_invalid();
    test_saturation();
    test_random_messages();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
